// File: rtl/synch_bin_down_count_if.sv
// synch_bin_down_count_if: control and status bundle for the down counter.
interface synch_bin_down_count_if #(parameter int Nbits = 4);
    logic             ena;
    logic             load;
    logic [Nbits-1:0] load_val;
    logic [Nbits-1:0] counter;
    logic             tc;
    logic             busy;
    modport master (output ena, load, load_val, input counter, tc, busy);
    modport slave  (input ena, load, load_val, output counter, tc, busy);
endinterface

// File: rtl/synch_bin_down_count.sv
// synch_bin_down_count: loadable down counter with IDLE/RUN/DONE FSM and one-cycle terminal-count pulse.
// Define SYNCH_BIN_DOWN_COUNT_RELOAD_EN to reload the last loaded value at terminal count instead of stopping.
module synch_bin_down_count #(
    parameter int Nbits = 4
) (
    input logic                   clk,
    input logic                   rst,
    synch_bin_down_count_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [Nbits-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             dec, term;
`ifdef SYNCH_BIN_DOWN_COUNT_RELOAD_EN
    logic [Nbits-1:0] reload_q, reload_d;
`endif
    assign dec  = state_q == RUN && bus.ena;
    assign term = dec && cnt_q == Nbits'(1);
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tc_d    = 1'b0;
`ifdef SYNCH_BIN_DOWN_COUNT_RELOAD_EN
        reload_d = reload_q;
`endif
        if (bus.load) begin
            cnt_d   = bus.load_val;
            state_d = bus.load_val != '0 ? RUN : DONE;
            tc_d    = bus.load_val == '0;
`ifdef SYNCH_BIN_DOWN_COUNT_RELOAD_EN
            reload_d = bus.load_val;
`endif
        end else if (term) begin
            tc_d = 1'b1;
`ifdef SYNCH_BIN_DOWN_COUNT_RELOAD_EN
            cnt_d = reload_q;
`else
            cnt_d   = '0;
            state_d = DONE;
`endif
        end else if (dec && cnt_q > Nbits'(1)) begin
            cnt_d = cnt_q - Nbits'(1);
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tc_q    <= 1'b0;
`ifdef SYNCH_BIN_DOWN_COUNT_RELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tc_q    <= tc_d;
`ifdef SYNCH_BIN_DOWN_COUNT_RELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end
    assign bus.counter = cnt_q;
    assign bus.tc      = tc_q;
    assign bus.busy    = state_q == RUN;
endmodule

// File: doc/synch_bin_down_count.md
SYNCH_BIN_DOWN_COUNT -- requirements
Module: synch_bin_down_count

Interface
REQ-001 Parameter SHALL be: Nbits, 4, counter width in bits (legal range 2..16).
REQ-002 Port SHALL be: clk  input  1  rising-edge clock; sole clock domain.
REQ-003 Port SHALL be: rst  input  1  reset; asynchronous, active-low.
REQ-004 Port SHALL be: ena  input  1  count enable; one decrement per clk edge while high in RUN.
REQ-005 Port SHALL be: load  input  1  synchronous load strobe; captures load_val.
REQ-006 Port SHALL be: load_val  input  Nbits  unsigned start value.
REQ-007 Port SHALL be: counter  output  Nbits  registered current count.
REQ-008 Port SHALL be: tc  output  1  registered terminal-count pulse, one clk wide.
REQ-009 Port SHALL be: busy  output  1  high exactly while FSM is in RUN.

Function
REQ-010 FSM SHALL have three states: IDLE, RUN, DONE; state, counter, tc all registered on rising clk.
REQ-011 load=1 SHALL have priority over ena in every state: counter<=load_val, reload_val<=load_val, tc<=0.
REQ-012 load with load_val!=0 SHALL enter RUN next cycle; load with load_val=0 SHALL enter DONE with counter=0 and tc=1 next cycle.
REQ-013 In RUN with ena=1, load=0, counter>1: counter SHALL decrement by 1, tc<=0.
REQ-014 In RUN with ena=1, load=0, counter=1: terminal event; tc<=1 for exactly one cycle; behaviour per REQ-022/REQ-023.
REQ-015 In RUN with ena=0: counter and state SHALL hold, tc<=0.
REQ-016 In IDLE and DONE: ena SHALL be ignored, counter held, tc<=0 unless REQ-012 applies.
REQ-017 Counter SHALL never wrap below 0; no decrement occurs from 0.
REQ-018 Load asserted in RUN SHALL restart the count from load_val in the next cycle (no tc for the aborted run).
REQ-019 Latency: load to first valid counter value = 1 cycle; N ena cycles after a load of N SHALL produce tc.
REQ-020 busy SHALL be decoded from registered state only (no combinational path from inputs).

Reset
REQ-021 rst=0 SHALL asynchronously force state=IDLE, counter=0, tc=0, busy=0, reload_val=0; release is synchronous to next clk.

Configuration
REQ-022 Macro SYNCH_BIN_DOWN_COUNT_RELOAD_EN defined: at terminal event counter<=reload_val, state stays RUN, tc pulse aligns with counter=reload_val; period = reload_val ena cycles.
REQ-023 Macro SYNCH_BIN_DOWN_COUNT_RELOAD_EN undefined: at terminal event counter<=0, state<=DONE, busy<=0; reload_val register SHALL not be implemented.

Verification
REQ-024 rst=0 mid-RUN at counter=5 -> counter=0, tc=0, busy=0 immediately, before next clk edge.
REQ-025 Nbits=4, load_val=3 then ena=1 continuous, macro off -> counter 3,2,1,0; tc=1 only in the cycle counter=0; busy falls with it; state DONE.
REQ-026 Same stimulus, macro on -> counter 3,2,1,3,2,1,3; tc=1 in each cycle counter returns to 3 after 1; busy stays 1.
REQ-027 load_val=15, ena toggling 1/0 -> counter decrements only on ena=1 cycles; tc after exactly 15 ena cycles.
REQ-028 load_val=0 -> next cycle counter=0, tc=1 for one cycle, busy=0, state DONE (both macro settings).
REQ-029 RUN at counter=2, load=1 with ena=1 and load_val=9 -> next counter=9, no tc, busy=1.
